// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider with staged per-channel configuration.
// Each channel has a 50% duty divided clock, a bypass, a rising-edge tick and a pending flag.
module clk_div_multi #(
  parameter int NCH     = 4,
  parameter int DIV_W   = 8,
  parameter int RST_DIV = 3,
  parameter int RST_EN  = 1,
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [DIV_W-1:0] i_cfg_div,
  input  logic             i_cfg_en,
  input  logic             i_cfg_byp,
  output logic [NCH-1:0]   o_clk,
  output logic [NCH-1:0]   o_tick,
  output logic [NCH-1:0]   o_pend
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [DIV_W-1:0] cur_div;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] pend_div;
    logic             en;
    logic             byp_r;
    logic             div_clk;
    logic             tick_r;
    logic             pend;
    logic             pend_en;
    logic             pend_byp;
    logic             wr_hit;
    logic             at_top;
    logic             fall;
    logic             apply;

    // Channel indices >= NCH match no channel, so such writes are dropped.
    assign wr_hit = i_cfg_we && (i_cfg_ch == CH_W'(c));
    assign at_top = en && (cnt == cur_div);
    assign fall   = at_top && div_clk;
    // Staged config lands only at a full-period end or while the channel sits stopped low.
    assign apply  = pend && (fall || (!div_clk && !en));

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        cur_div  <= DIV_W'(RST_DIV);
        en       <= (RST_EN != 0);
        byp_r    <= 1'b0;
        cnt      <= '0;
        div_clk  <= 1'b0;
        tick_r   <= 1'b0;
        pend     <= 1'b0;
        pend_div <= '0;
        pend_en  <= 1'b0;
        pend_byp <= 1'b0;
      end else begin
        if (apply) begin
          cur_div <= pend_div;
          en      <= pend_en;
          byp_r   <= pend_byp;
          cnt     <= '0;
          div_clk <= 1'b0;
        end else if (at_top) begin
          cnt     <= '0;
          div_clk <= ~div_clk;
        end else if (en) begin
          cnt     <= cnt + DIV_W'(1);
        end else begin
          cnt     <= '0;
          div_clk <= 1'b0;
        end

        tick_r <= at_top && !div_clk;

        // A write on the apply cycle wins the pending slot, so pend stays set.
        if (wr_hit) begin
          pend     <= 1'b1;
          pend_div <= i_cfg_div;
          pend_en  <= i_cfg_en;
          pend_byp <= i_cfg_byp;
        end else if (apply) begin
          pend     <= 1'b0;
        end
      end
    end

    assign o_clk[c]  = byp_r ? i_clk : div_clk;
    assign o_tick[c] = tick_r;
    assign o_pend[c] = pend;
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: a cycle table for reset/idle and a mid-phase rewrite,
// then hand-timed sequences for double writes, disable/re-enable, bypass, ignored channel and reset.
module tb_clk_div_multi;

  logic       clk;
  logic       rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic       cfg_en;
  logic       cfg_byp;
  logic [3:0] o_clk;
  logic [3:0] o_tick;
  logic [3:0] o_pend;
  logic [2:0] o_clk3;
  logic [2:0] o_tick3;
  logic [2:0] o_pend3;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(.NCH(4), .DIV_W(8), .RST_DIV(3), .RST_EN(1)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
    .i_cfg_div(cfg_div), .i_cfg_en(cfg_en), .i_cfg_byp(cfg_byp),
    .o_clk(o_clk), .o_tick(o_tick), .o_pend(o_pend)
  );

  // Three-channel copy so that a 2-bit channel index can address a non-existent channel.
  clk_div_multi #(.NCH(3), .DIV_W(8), .RST_DIV(3), .RST_EN(1)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_ch(cfg_ch),
    .i_cfg_div(cfg_div), .i_cfg_en(cfg_en), .i_cfg_byp(cfg_byp),
    .o_clk(o_clk3), .o_tick(o_tick3), .o_pend(o_pend3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [7:0] div;
    logic       en;
    logic       byp;
    logic [3:0] exp_clk;
    logic [3:0] exp_tick;
    logic [3:0] exp_pend;
  } vec_t;

  vec_t vecs[32];

  function automatic vec_t mk(input logic we, input logic [1:0] ch, input logic [7:0] div,
                              input logic [3:0] eclk, input logic [3:0] etick,
                              input logic [3:0] epend);
    vec_t v;
    v.we = we; v.ch = ch; v.div = div; v.en = 1'b1; v.byp = 1'b0;
    v.exp_clk = eclk; v.exp_tick = etick; v.exp_pend = epend;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic atNegedge();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    cfg_we  = v.we;
    cfg_ch  = v.ch;
    cfg_div = v.div;
    cfg_en  = v.en;
    cfg_byp = v.byp;
    step();
    cfg_we  = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [7:0] div, input logic en,
                    input logic byp);
    cfg_we = 1'b1; cfg_ch = ch; cfg_div = div; cfg_en = en; cfg_byp = byp;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    cycles(2);
    checkOutput("reset clk", 32'(o_clk), 32'h0);
    checkOutput("reset tick", 32'(o_tick), 32'h0);
    checkOutput("reset pend", 32'(o_pend), 32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0; cfg_en = 1'b0; cfg_byp = 1'b0;

    // Rows are indexed by edges since reset release; ch1 gets D=0 mid high phase at edge 22.
    for (int i = 0; i < 3; i++)   vecs[i] = mk(1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0);
    vecs[3] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0);
    for (int i = 4; i < 7; i++)   vecs[i] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0);
    for (int i = 7; i < 11; i++)  vecs[i] = mk(1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0);
    vecs[11] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0);
    for (int i = 12; i < 15; i++) vecs[i] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0);
    for (int i = 15; i < 19; i++) vecs[i] = mk(1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0);
    vecs[19] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'hF, 4'h0);
    vecs[20] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h0);
    vecs[21] = mk(1'b1, 2'd1, 8'd0, 4'hF, 4'h0, 4'h2);
    vecs[22] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'h2);
    vecs[23] = mk(1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0);
    vecs[24] = mk(1'b0, 2'd0, 8'd0, 4'h2, 4'h2, 4'h0);
    vecs[25] = mk(1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0);
    vecs[26] = mk(1'b0, 2'd0, 8'd0, 4'h2, 4'h2, 4'h0);
    vecs[27] = mk(1'b0, 2'd0, 8'd0, 4'hD, 4'hD, 4'h0);
    vecs[28] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'h2, 4'h0);
    vecs[29] = mk(1'b0, 2'd0, 8'd0, 4'hD, 4'h0, 4'h0);
    vecs[30] = mk(1'b0, 2'd0, 8'd0, 4'hF, 4'h2, 4'h0);
    vecs[31] = mk(1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0);

    #2;
    doReset();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d clk", i + 1), 32'(o_clk), 32'(vecs[i].exp_clk));
      checkOutput($sformatf("vec%0d tick", i + 1), 32'(o_tick), 32'(vecs[i].exp_tick));
      checkOutput($sformatf("vec%0d pend", i + 1), 32'(o_pend), 32'(vecs[i].exp_pend));
      checkOutput($sformatf("vec%0d clk3", i + 1), 32'(o_clk3), 32'(vecs[i].exp_clk[2:0]));
    end

    // Two writes to ch0 before the boundary, then a write on the apply cycle itself.
    doReset();
    cycles(1);
    wr(2'd0, 8'd5, 1'b1, 1'b0);
    checkOutput("dbl pend k2", 32'(o_pend[0]), 32'h1);
    wr(2'd0, 8'd1, 1'b1, 1'b0);
    cycles(1);
    checkOutput("dbl rise k4", 32'(o_clk[0]), 32'h1);
    cycles(3);
    checkOutput("dbl pend k7", 32'(o_pend[0]), 32'h1);
    cycles(1);
    checkOutput("dbl fall k8", 32'(o_clk[0]), 32'h0);
    checkOutput("dbl applied k8", 32'(o_pend[0]), 32'h0);
    cycles(1);
    checkOutput("dbl low k9", 32'(o_clk[0]), 32'h0);
    wr(2'd0, 8'd2, 1'b1, 1'b0);
    checkOutput("dbl d1 rise k10", 32'(o_clk[0]), 32'h1);
    checkOutput("dbl d1 tick k10", 32'(o_tick[0]), 32'h1);
    cycles(1);
    checkOutput("dbl d1 high k11", 32'(o_clk[0]), 32'h1);
    wr(2'd0, 8'd0, 1'b1, 1'b0);
    checkOutput("dbl d1 fall k12", 32'(o_clk[0]), 32'h0);
    checkOutput("same-cycle pend k12", 32'(o_pend[0]), 32'h1);
    checkOutput("ch1 undisturbed k12", 32'(o_clk[1]), 32'h1);
    cycles(2);
    checkOutput("d2 low k14", 32'(o_clk[0]), 32'h0);
    cycles(1);
    checkOutput("d2 rise k15", 32'(o_clk[0]), 32'h1);
    checkOutput("d2 tick k15", 32'(o_tick[0]), 32'h1);
    cycles(3);
    checkOutput("d2 fall k18", 32'(o_clk[0]), 32'h0);
    checkOutput("d0 applied k18", 32'(o_pend[0]), 32'h0);
    cycles(1);
    checkOutput("d0 rise k19", 32'(o_clk[0]), 32'h1);
    cycles(1);
    checkOutput("d0 fall k20", 32'(o_clk[0]), 32'h0);

    // Disable ch2, confirm it stays silent, then re-enable with D=2 while stopped.
    doReset();
    wr(2'd2, 8'd3, 1'b0, 1'b0);
    checkOutput("dis pend k1", 32'(o_pend[2]), 32'h1);
    cycles(3);
    checkOutput("dis last tick k4", 32'(o_tick[2]), 32'h1);
    cycles(4);
    checkOutput("dis low k8", 32'(o_clk[2]), 32'h0);
    checkOutput("dis applied k8", 32'(o_pend[2]), 32'h0);
    for (int k = 9; k <= 20; k++) begin
      step();
      checkOutput($sformatf("dis quiet k%0d", k), {30'd0, o_clk[2], o_tick[2]}, 32'h0);
    end
    wr(2'd2, 8'd2, 1'b1, 1'b0);
    checkOutput("reen pend k21", 32'(o_pend[2]), 32'h1);
    cycles(1);
    checkOutput("reen applied k22", 32'(o_pend[2]), 32'h0);
    cycles(2);
    checkOutput("reen low k24", 32'(o_clk[2]), 32'h0);
    cycles(1);
    checkOutput("reen rise k25", 32'(o_clk[2]), 32'h1);
    checkOutput("reen tick k25", 32'(o_tick[2]), 32'h1);
    cycles(2);
    checkOutput("reen high k27", 32'(o_clk[2]), 32'h1);
    cycles(1);
    checkOutput("reen fall k28", 32'(o_clk[2]), 32'h0);
    cycles(2);
    checkOutput("reen low k30", 32'(o_clk[2]), 32'h0);
    cycles(1);
    checkOutput("reen rise k31", 32'(o_clk[2]), 32'h1);

    // Bypass on ch3, then back to a divided output with D=1.
    doReset();
    wr(2'd3, 8'd3, 1'b1, 1'b1);
    cycles(6);
    checkOutput("byp pre k7", 32'(o_clk[3]), 32'h1);
    atNegedge();
    checkOutput("byp pre neg k7", 32'(o_clk[3]), 32'h1);
    cycles(1);
    checkOutput("byp on k8", 32'(o_clk[3]), 32'h1);
    checkOutput("byp applied k8", 32'(o_pend[3]), 32'h0);
    atNegedge();
    checkOutput("byp on neg k8", 32'(o_clk[3]), 32'h0);
    cycles(2);
    checkOutput("byp follows k10", 32'(o_clk[3]), 32'h1);
    cycles(2);
    checkOutput("byp tick k12", 32'(o_tick[3]), 32'h1);
    wr(2'd3, 8'd1, 1'b1, 1'b0);
    cycles(2);
    checkOutput("byp still k15", 32'(o_clk[3]), 32'h1);
    atNegedge();
    checkOutput("byp still neg k15", 32'(o_clk[3]), 32'h0);
    cycles(1);
    checkOutput("unbyp k16", 32'(o_clk[3]), 32'h0);
    checkOutput("unbyp applied k16", 32'(o_pend[3]), 32'h0);
    atNegedge();
    checkOutput("unbyp neg k16", 32'(o_clk[3]), 32'h0);
    cycles(1);
    checkOutput("unbyp low k17", 32'(o_clk[3]), 32'h0);
    cycles(1);
    checkOutput("unbyp rise k18", 32'(o_clk[3]), 32'h1);
    checkOutput("unbyp tick k18", 32'(o_tick[3]), 32'h1);
    cycles(1);
    checkOutput("unbyp high k19", 32'(o_clk[3]), 32'h1);
    cycles(1);
    checkOutput("unbyp fall k20", 32'(o_clk[3]), 32'h0);

    // Channel index 3 does not exist in the three-channel copy.
    doReset();
    wr(2'd3, 8'd0, 1'b0, 1'b0);
    checkOutput("bad ch ignored pend", 32'(o_pend3), 32'h0);
    checkOutput("ch3 write taken", 32'(o_pend[3]), 32'h1);
    cycles(3);
    checkOutput("bad ch clk3 k4", 32'(o_clk3), 32'h7);

    // Reset with writes pending on every channel.
    doReset();
    wr(2'd0, 8'd7, 1'b1, 1'b1);
    wr(2'd1, 8'd7, 1'b1, 1'b1);
    wr(2'd2, 8'd7, 1'b1, 1'b1);
    wr(2'd3, 8'd7, 1'b1, 1'b1);
    checkOutput("all pend k4", 32'(o_pend), 32'hF);
    cycles(1);
    checkOutput("all high k5", 32'(o_clk), 32'hF);
    rst_n = 1'b0;
    step();
    checkOutput("midrst clk", 32'(o_clk), 32'h0);
    checkOutput("midrst pend", 32'(o_pend), 32'h0);
    checkOutput("midrst tick", 32'(o_tick), 32'h0);
    rst_n = 1'b1;
    cycles(3);
    checkOutput("postrst low k3", 32'(o_clk), 32'h0);
    cycles(1);
    checkOutput("postrst rise k4", 32'(o_clk), 32'hF);
    checkOutput("postrst tick k4", 32'(o_tick), 32'hF);
    cycles(4);
    checkOutput("postrst fall k8", 32'(o_clk), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
Name: clk_div_multi

Overview:
- Parametrised multi-channel successor to the single-output power-of-two clock divider.
- Produces NCH independent divided clocks from one source clock. Each channel has:
  - an arbitrary integer divisor (50% duty),
  - a clean enable/stop,
  - a bypass to the source clock,
  - a rising-edge tick strobe.
- Configuration writes are staged and take effect only at a full-period boundary, so a running output never sees a truncated phase. Sits beside the core/peripheral clock tree, driven by a config register block.

Parameters:
- NCH, 4, number of output channels (1..16)
- DIV_W, 8, divisor field and counter width
- RST_DIV, 3, divisor loaded into every channel at reset
- RST_EN, 1, channel enable state after reset

Ports:
- i_clk  in  1  source clock; all logic on posedge
- i_rst_n  in  1  synchronous active-low reset
- i_cfg_we  in  1  config write strobe, one cycle
- i_cfg_ch  in  max(1,clog2(NCH))  target channel
- i_cfg_div  in  DIV_W  new divisor D
- i_cfg_en  in  1  new enable
- i_cfg_byp  in  1  new bypass select
- o_clk  out  NCH  per-channel clock: byp_r ? i_clk : div_clk
- o_tick  out  NCH  one-cycle pulse per divided rising edge
- o_pend  out  NCH  staged config not yet applied

Behaviour:
- Reset (i_rst_n=0 at posedge), per channel:
  - cur_div=RST_DIV, en=RST_EN, byp_r=0
  - cnt=0, div_clk=0, o_tick=0, pend=0
  - o_clk therefore reads 0 after reset.
- Divide rule: div_clk toggles every D+1 i_clk cycles, giving period 2*(D+1) and exact 50% duty. D=0 gives i_clk/2; D=2^DIV_W-1 is the maximum.
- Counter:
  - When running, cnt increments 0..cur_div.
  - At cnt==cur_div: cnt<=0 and div_clk toggles.
  - All arithmetic is unsigned DIV_W; cnt never exceeds cur_div.
- Tick: o_tick asserts for exactly the one cycle in which registered div_clk is 1 after being 0. It is registered and aligned with the divided rising edge.
- Write staging:
  - i_cfg_we with i_cfg_ch<NCH captures {div,en,byp} into that channel's pending register and sets pend.
  - Writes with i_cfg_ch>=NCH are ignored.
  - A new write overwrites an unapplied pending value.
- Apply point: the pending value loads into {cur_div,en,byp_r} and pend clears at either of:
  - (a) the toggle cycle where div_clk goes 1->0, which is the full-period end, or
  - (b) any cycle while the channel is stopped (div_clk=0 and en=0).
  - On load, cnt restarts at 0.
- Simultaneous write and apply in the same cycle: the old pending value is applied, the new write is captured, and pend stays 1.
- Disable (en=0 applied):
  - The channel finishes nothing further: it is already low at the apply point.
  - cnt is held at 0, div_clk=0, no ticks.
- Re-enable: first div_clk rise occurs cur_div+1 cycles after apply.
- Bypass:
  - byp_r changes only at an apply point, where div_clk=0.
  - Entering bypass yields a rising edge aligned to i_clk; no runt pulse.
  - Leaving bypass may emit at most one truncated high phase no longer than i_clk high time. This is a documented limitation.
  - Ticks continue while in bypass if en=1.
- Channel independence: channels share only i_clk/i_rst_n; a write to one channel never perturbs another's cnt or phase.
- Reset mid-operation: reset is immediate at the next posedge regardless of phase or pending state; the pending value is discarded.

Test Plan:
- Reset then idle with RST_DIV=3 -> every o_clk low for 4 cycles, high for 4, period 8. First o_tick at cycle 4 after reset release, then every 8 cycles.
- Ch1 running D=3, write D=0 mid-high-phase -> the current high phase completes at 4 cycles. From the next low phase, period is 2. o_pend is high from the write until the 1->0 toggle. Other channels are unchanged.
- Two writes to ch0 (D=5, then D=1) before the boundary -> only D=1 is applied, giving period 4. A write landing on the apply cycle leaves o_pend=1 and applies at the following boundary.
- Write en=0 on ch2 -> ch2 stops low at the next period end with no further ticks. Write en=1, D=2 while stopped -> applied the next cycle, first rise 3 cycles later, period 6.
- Write byp=1 on ch3 -> from the apply point o_clk[3] equals i_clk with no runt pulse. Write byp=0 -> at most one short high phase, then period 2*(D+1). i_cfg_ch=NCH is ignored.
- Assert i_rst_n=0 with pending writes on all channels -> all outputs and o_pend are 0 next cycle, and the divisor returns to RST_DIV.
